// File: rtl/wb_regs_v2_pkg.sv
// Shared decode type and byte-lane mask helper for the wb_regs register slave.
package wb_regs_pkg;

  typedef enum logic [1:0] {DEC_CTL, DEC_STS, DEC_MISS} decode_t;

  localparam int LM_MAXB = 8;
  localparam int LM_MAXW = 8 * LM_MAXB;

  // Expands byte selects to a bit mask, with bits at or above width forced to 0.
  function automatic logic [LM_MAXW-1:0] lane_mask(input logic [LM_MAXB-1:0] sel,
                                                   input int width);
    logic [LM_MAXW-1:0] m;
    m = '0;
    for (int i = 0; i < LM_MAXW; i++)
      if (i < width && sel[i/8]) m[i] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/wb_regs_v2_sticky.sv
// One write-1-to-clear status latch; a set in the same cycle as a clear wins.
module wb_sticky_reg #(
  parameter int REGW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [REGW-1:0] set_i,
  input  logic [REGW-1:0] clr_i,
  output logic [REGW-1:0] q_o
);

  logic [REGW-1:0] q_q, q_d;

  always_comb q_d = (q_q & ~clr_i) | set_i;

  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/wb_regs_v2.sv
// Pipelined Wishbone slave with control registers, status/sticky registers and an IRQ.
module wb_regs_v2
  import wb_regs_pkg::*;
#(
  parameter int                    CFGAW       = 32,
  parameter int                    CFGDW       = 32,
  parameter int                    REGW        = 32,
  parameter int                    N_CTL       = 32,
  parameter int                    N_STS       = 32,
  parameter bit                    SIGN_EXTEND = 1'b1,
  parameter logic [N_CTL*REGW-1:0] CTL_INIT    = '0,
  parameter logic [N_STS-1:0]      STICKY_MASK = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cyc_i,
  input  logic                        stb_i,
  input  logic                        we_i,
  input  logic [CFGDW/8-1:0]          sel_i,
  input  logic [CFGAW-1:0]            addr_i,
  input  logic [CFGDW-1:0]            data_i,
  output logic [CFGDW-1:0]            data_o,
  output logic                        ack_o,
  output logic                        err_o,
  output logic                        stall_o,
  output logic [N_CTL-1:0][REGW-1:0]  ctl_regs,
  output logic [N_CTL-1:0]            ctl_wr_o,
  input  logic [N_STS-1:0][REGW-1:0]  sts_regs,
  output logic                        irq_o
);

  localparam int AW1 = CFGAW + 1;
  localparam int CIW = (N_CTL > 1) ? $clog2(N_CTL) : 1;
  localparam int SIW = (N_STS > 1) ? $clog2(N_STS) : 1;

  function automatic logic [CFGDW-1:0] ext(input logic [REGW-1:0] v);
    logic [CFGDW-1:0] r;
    r = {CFGDW{SIGN_EXTEND && v[REGW-1]}};
    r[REGW-1:0] = v;
    return r;
  endfunction

  logic [N_CTL-1:0][REGW-1:0] ctl_q, ctl_d;
  logic [N_CTL-1:0]           wr_q, wr_d;
  logic [N_STS-1:0][REGW-1:0] sticky_q, clr;
  logic [CFGDW-1:0]           data_q, data_d;
  logic                       ack_q, ack_d, err_q, err_d, irq_q;

  logic [AW1-1:0]     addr_x, sts_off;
  logic [CIW-1:0]     ctl_idx;
  logic [SIW-1:0]     sts_idx;
  logic [LM_MAXB-1:0] sel_ext;
  logic [LM_MAXW-1:0] lmask;
  logic [REGW-1:0]    wmask, wdat;
  decode_t            dec;

  assign addr_x  = {1'b0, addr_i};
  assign sts_off = addr_x - AW1'(N_CTL);
  assign ctl_idx = addr_i[CIW-1:0];
  assign sts_idx = sts_off[SIW-1:0];
  assign sel_ext = LM_MAXB'(sel_i);
  assign lmask   = lane_mask(sel_ext, REGW);
  assign wmask   = lmask[REGW-1:0];
  assign wdat    = data_i[REGW-1:0];

  always_comb begin
    if (addr_x < AW1'(N_CTL))              dec = DEC_CTL;
    else if (addr_x < AW1'(N_CTL + N_STS)) dec = DEC_STS;
    else                                   dec = DEC_MISS;
  end

  // Reads always see the register contents from before this cycle's edge.
  always_comb begin
    ctl_d  = ctl_q;
    wr_d   = '0;
    ack_d  = 1'b0;
    err_d  = 1'b0;
    data_d = data_q;
    clr    = '0;
    if (cyc_i && stb_i) begin
      case (dec)
        DEC_CTL: begin
          ack_d = 1'b1;
          if (we_i) begin
            wr_d[ctl_idx]  = 1'b1;
            ctl_d[ctl_idx] = (ctl_q[ctl_idx] & ~wmask) | (wdat & wmask);
          end else begin
            data_d = ext(ctl_q[ctl_idx]);
          end
        end
        DEC_STS: begin
          if (we_i) begin
            if (STICKY_MASK[sts_idx]) begin
              ack_d        = 1'b1;
              clr[sts_idx] = wdat & wmask;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            ack_d  = 1'b1;
            data_d = ext(STICKY_MASK[sts_idx] ? sticky_q[sts_idx] : sts_regs[sts_idx]);
          end
        end
        default: err_d = 1'b1;
      endcase
    end
  end

  for (genvar j = 0; j < N_STS; j++) begin : g_sts
    if (STICKY_MASK[j]) begin : g_sticky
      wb_sticky_reg #(.REGW(REGW)) u_sticky (
        .clk   (clk),
        .rst   (rst),
        .set_i (sts_regs[j]),
        .clr_i (clr[j]),
        .q_o   (sticky_q[j])
      );
    end else begin : g_plain
      assign sticky_q[j] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctl_q  <= CTL_INIT;
      wr_q   <= '0;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      data_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      ctl_q  <= ctl_d;
      wr_q   <= wr_d;
      ack_q  <= ack_d;
      err_q  <= err_d;
      data_q <= data_d;
      irq_q  <= |sticky_q;
    end
  end

  assign ctl_regs = ctl_q;
  assign ctl_wr_o = wr_q;
  assign data_o   = data_q;
  assign ack_o    = ack_q;
  assign err_o    = err_q;
  assign irq_o    = irq_q;
  assign stall_o  = 1'b0;

endmodule
